// File: rtl/binary_arith_pkg.sv
// ============================================================================
// binary_arith_pkg : shared widths, iteration count and state encoding for
//                    the shift-add multiplier and restoring divider.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package binary_arith_pkg;

    localparam int MCAND_W    = 64;
    localparam int MPLIER_W   = 32;
    localparam int PROD_W     = 96;
    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        COMPLETE = 2'b11
    } state_t;

endpackage

`default_nettype wire

// File: rtl/binary_multiplier.sv
// ============================================================================
// binary_multiplier : 32-iteration shift-add multiply-accumulate,
//                     product = multiplicand * multiplier + addend.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_multiplier
    import binary_arith_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                mul_en,
    input  logic [MCAND_W-1:0]  g_multiplicand,
    input  logic [MPLIER_W-1:0] g_multiplier,
    input  logic [MCAND_W-1:0]  g_addend,
    output logic [PROD_W-1:0]   product,
    output logic                busy,
    output logic                done
);

    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(ITER_COUNT - 1);

    state_t                state_q,   state_d;
    logic [PROD_W-1:0]     mcand_q,   mcand_d;
    logic [MPLIER_W-1:0]   mplier_q,  mplier_d;
    logic [PROD_W-1:0]     acc_q,     acc_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [PROD_W-1:0]     product_q, product_d;
    logic                  done_q,    done_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (mul_en) begin
                    mcand_d  = {{(PROD_W-MCAND_W){1'b0}}, g_multiplicand};
                    mplier_d = g_multiplier;
                    acc_d    = {{(PROD_W-MCAND_W){1'b0}}, g_addend};
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Result cannot exceed 2^96 - 2^32, so the 96-bit sum never wraps.
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == c_LAST_CNT) begin
                    state_d = COMPLETE;
                end
            end
            COMPLETE: begin
                product_d = acc_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = product_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_binary_multiplier.sv
// ============================================================================
// tb_binary_multiplier : directed self-checking bench for binary_multiplier.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_binary_multiplier;

    logic        clk;
    logic        reset;
    logic        mul_en;
    logic [63:0] g_multiplicand;
    logic [31:0] g_multiplier;
    logic [63:0] g_addend;
    logic [95:0] product;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    binary_multiplier u_dut (
        .clk            (clk),
        .reset          (reset),
        .mul_en         (mul_en),
        .g_multiplicand (g_multiplicand),
        .g_multiplier   (g_multiplier),
        .g_addend       (g_addend),
        .product        (product),
        .busy           (busy),
        .done           (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts one operation, then checks latency, done width, busy window and result.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [31:0] b,
                          input logic [63:0] c, input logic [95:0] exp);
        int n;
        @(negedge clk);
        g_multiplicand = a;
        g_multiplier   = b;
        g_addend       = c;
        mul_en         = 1'b1;
        @(posedge clk);
        #1;
        mul_en         = 1'b0;
        g_multiplicand = ~a;
        g_multiplier   = ~b;
        g_addend       = ~c;
        chk({tag, "_busy_e0"}, 96'(busy), 96'd1);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 32) chk({tag, "_busy_e32"}, 96'(busy), 96'd1);
            if (done) break;
        end
        chk({tag, "_latency"}, 96'(n), 96'd33);
        chk({tag, "_prod"}, product, exp);
        chk({tag, "_busy_e33"}, 96'(busy), 96'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_e34"}, 96'(done), 96'd0);
        chk({tag, "_hold"}, product, exp);
    endtask

    initial begin
        int d1;
        int d2;
        reset          = 1'b1;
        mul_en         = 1'b0;
        g_multiplicand = '0;
        g_multiplier   = '0;
        g_addend       = '0;
        #1;
        chk("rst_prod", product, 96'd0);
        chk("rst_busy", 96'(busy), 96'd0);
        chk("rst_done", 96'(done), 96'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run_op("small", 64'd5, 32'd3, 64'd0, 96'd15);
        run_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               96'hFFFF_FFFF_FFFF_FFFF_0000_0000);
        run_op("mz", 64'hDEAD_BEEF, 32'd0, 64'h1234, 96'h1234);
        run_op("trip", 64'd7, 32'd142, 64'd6, 96'd1000);

        // Back-to-back with mul_en held high; second operands applied during first run.
        @(negedge clk);
        g_multiplicand = 64'd5;
        g_multiplier   = 32'd3;
        g_addend       = 64'd0;
        mul_en         = 1'b1;
        @(posedge clk);
        #1;
        g_multiplicand = 64'd7;
        g_multiplier   = 32'd6;
        g_addend       = 64'd1;
        d1 = -1;
        d2 = -1;
        for (int e = 1; e <= 70; e++) begin
            @(posedge clk);
            #1;
            if (e == 34) begin
                mul_en         = 1'b0;
                g_multiplicand = 64'd99;
                g_multiplier   = 32'd99;
                g_addend       = 64'd99;
            end
            if (done && d1 < 0) begin
                d1 = e;
                chk("b2b_prod1", product, 96'd15);
            end else if (done && d2 < 0) begin
                d2 = e;
                chk("b2b_prod2", product, 96'd43);
            end
        end
        chk("b2b_done1_edge", 96'(d1), 96'd33);
        chk("b2b_done2_edge", 96'(d2), 96'd67);

        // Abort at RUN iteration 10; product holds 43 beforehand, so clearing is visible.
        @(negedge clk);
        g_multiplicand = 64'd1000;
        g_multiplier   = 32'd1000;
        g_addend       = 64'd5;
        mul_en         = 1'b1;
        @(posedge clk);
        #1;
        mul_en = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_prod", product, 96'd0);
        chk("abort_busy", 96'(busy), 96'd0);
        chk("abort_done", 96'(done), 96'd0);
        @(negedge clk);
        reset = 1'b0;
        d1 = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk);
            #1;
            if (done || busy) d1++;
        end
        chk("abort_no_done", 96'(d1), 96'd0);
        run_op("post_rst", 64'd7, 32'd6, 64'd1, 96'd43);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
